// File: rtl/my_ram_pkg.sv
// Shared constants and types for the 8-word, 16-bit my_ram_8 register file
// and the FIFO controller that fronts it.
package my_ram_pkg;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef logic [WIDTH-1:0]  word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/my_ram_8_fifo.sv
// Valid/ready FIFO controller driving a single-port my_ram_8 register file.
// Capacity is the RAM depth plus one registered pop output stage.
module my_ram_8_fifo #(
   parameter int unsigned WIDTH  = my_ram_pkg::WIDTH,
   parameter int unsigned ADDR_W = my_ram_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  push_data,
   input  logic              push_valid,
   output logic              push_ready,
   output logic [WIDTH-1:0]  pop_data,
   output logic              pop_valid,
   input  logic              pop_ready,
   output logic [ADDR_W:0]   level,
   input  logic [WIDTH-1:0]  ram_out,
   output logic [WIDTH-1:0]  ram_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_load
);
   import my_ram_pkg::*;

   localparam int unsigned LP_DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(LP_DEPTH);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_ram_cnt;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_q;

   logic w_fetch;
   logic w_pop;

   // Single-port RAM: a refill of the output stage takes the port ahead of a push.
   assign w_fetch = (r_ram_cnt != '0) && (!r_out_valid || pop_ready);
   assign w_pop   = r_out_valid && pop_ready;

   always_comb begin
      ram_addr   = r_wr_ptr;
      push_ready = 1'b0;
      if (w_fetch) begin
         ram_addr = r_rd_ptr;
      end else begin
         push_ready = rst_n && (r_ram_cnt != LP_FULL);
      end
   end

   assign ram_load  = push_valid && push_ready;
   assign ram_in    = push_data;
   assign pop_data  = r_out_q;
   assign pop_valid = r_out_valid;
   assign level     = rst_n ? (r_ram_cnt + {{ADDR_W{1'b0}}, r_out_valid}) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_out_q     <= '0;
      end else if (w_fetch) begin
         // A pop in this cycle is covered by the refill, so valid stays high.
         r_out_q     <= ram_out;
         r_out_valid <= 1'b1;
         r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
         r_ram_cnt   <= r_ram_cnt - (ADDR_W+1)'(1);
      end else begin
         if (ram_load) begin
            r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
            r_ram_cnt <= r_ram_cnt + (ADDR_W+1)'(1);
         end
         if (w_pop) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/my_ram_8_fifo.md
Name: my_ram_8_fifo

Overview:
- FIFO controller that sits directly in front of the 8-word, 16-bit `my_ram_8` register file.
- It drives the RAM's in/addr/load ports and consumes its out port, turning the bare RAM into a valid/ready queue.
- The RAM holds up to 8 entries; one extra entry lives in a registered pop output stage, giving a total capacity of 9.
- The RAM is instantiated by the parent on the same clk.

Parameters:
- WIDTH, 16, data word width; must match the RAM.
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W = 8.

Ports:
- clk  in  1  system clock; rising edge; shared with the RAM.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- push_data  in  WIDTH  data to enqueue.
- push_valid  in  1  producer offers push_data.
- push_ready  out  1  controller accepts push_data this cycle.
- pop_data  out  WIDTH  head-of-queue data (registered).
- pop_valid  out  1  pop_data holds a valid entry.
- pop_ready  in  1  consumer takes pop_data this cycle.
- level  out  ADDR_W+1  total occupancy, 0..9, equal to ram_cnt + pop_valid.
- ram_out  in  WIDTH  RAM read data; combinational from ram_addr.
- ram_in  out  WIDTH  RAM write data; wired directly to push_data.
- ram_addr  out  ADDR_W  RAM address.
- ram_load  out  1  RAM write enable; the RAM writes on the rising clk while this is high.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDR_W bits each, wrap 7→0 naturally.
  - ram_cnt: ADDR_W+1 bits, range 0..8.
  - out_valid drives pop_valid.
  - out_q drives pop_data.
- Reset (rst_n=0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, out_valid=0, out_q=0.
  - RAM contents are not cleared.
  - While rst_n=0: ram_load=0, push_ready=0, level=0.
  - Reset wins over any simultaneous push or pop; in-flight data is discarded.
- Per-cycle mode select (combinational): fetch = (ram_cnt!=0) && (!out_valid || pop_ready).
- FETCH cycle (fetch=1):
  - ram_addr=rd_ptr, ram_load=0, push_ready=0.
  - On edge: out_q<=ram_out, out_valid<=1, rd_ptr+=1, ram_cnt-=1.
  - A concurrent pop (out_valid&&pop_ready) is satisfied by this refill, so out_valid stays 1.
- WRITE cycle (fetch=0):
  - ram_addr=wr_ptr, push_ready = rst_n && (ram_cnt!=8), ram_load = push_valid && push_ready.
  - On edge, if ram_load: wr_ptr+=1, ram_cnt+=1.
  - If out_valid && pop_ready: out_valid<=0; out_q holds its value.
- Read priority: reads have priority over writes because the RAM is single-port.
  - A consumer holding pop_ready high with ram_cnt>0 stalls pushes.
  - Steady push+pop throughput is therefore 1 word per 2 cycles; this is accepted.
- Latency: a push into an empty FIFO appears on pop_valid 2 edges after acceptance (write edge, then fetch edge). There is no bypass path.
- Full condition: ram_cnt=8 and out_valid=1 (level=9) → push_ready=0.
  - If out_valid=0 while ram_cnt=8, the next cycle is a fetch; push_ready is 0 in that cycle and becomes 1 the cycle after.
- Empty condition: level=0 → pop_valid=0. pop_ready while pop_valid=0 is ignored.
- Ordering: strict FIFO order across pointer wrap-around (entry 8 goes to address 0 again).
- Handshake rules:
  - push_data is sampled only when push_valid && push_ready.
  - pop_data/pop_valid are stable until the pop is accepted.
  - push_ready never depends combinationally on push_valid.
- ram_in equals push_data at all times; ram_load is the only write qualifier.

Decomposition:
- Shared package my_ram_pkg:
  - WIDTH=16, ADDR_W=3, DEPTH=8 constants.
  - typedef word_t (logic [15:0]).
  - typedef addr_t (logic [2:0]).
- Single module, no sub-module.
- Pointer/count logic stays inline. A separate counter module is not warranted at this size.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with push_valid=1 → pop_valid=0, level=0, ram_load=0 throughout. After release, push_ready=1.
- Fill to full: push 2,3,...,10 with pop_ready=0 and push_valid held high.
  - Pushes interleave with a single fetch cycle.
  - 9 words are accepted, then push_ready=0 and level=9; pop_data=2.
- Drain in order: from the full state, pop_ready=1 → pop_data sequence 2..10, then pop_valid=0, level=0.
- Wrap-around: push 11..16, drain, then push 17..22 → pointers wrap past 7 and the popped order is exactly 17..22.
- Simultaneous push+pop (both valid/ready held for 20 cycles, data counting from 100):
  - Output follows 100,101,... with no loss or duplication.
  - push_ready alternates, and level never exceeds 2.
- Mid-operation reset: with level=5, assert rst_n=0 for one edge → level=0, pop_valid=0. A subsequent push of 42 pops as 42.
